// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, word constants, instruction field slices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam int unsigned INST_W = 32;

    // Word presented to decode whenever no real instruction is held.
    localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0000;

    // Sequential fetch increment (byte-addressed 32-bit words).
    localparam int unsigned PC_STEP = 4;

    // Instruction field positions, shared with the control unit decoder.
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNC_MSB   = 5;
    localparam int unsigned FUNC_LSB   = 0;
    localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int unsigned FUNC_W     = FUNC_MSB - FUNC_LSB + 1;

    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INST_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [FUNC_W-1:0] get_func(input logic [INST_W-1:0] word);
        return word[FUNC_MSB:FUNC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, decode valid/ready, redirect and halt.
// Latency: n/a (wires only).
// Backpressure: imem_ack stalls the fetch side, inst_ready stalls the decode side.
//
// master: the fetch stage (drives imem_req/imem_addr and the decode-facing outputs)
// slave : memory + decode/control side (drives ack/rdata, ready, redirect, halt)
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 32
);
    import instr_fetch_pkg::*;

    // instruction memory
    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [INST_W-1:0]   imem_rdata;

    // decode side
    logic                inst_valid;
    logic                inst_ready;
    logic [INST_W-1:0]   inst;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC_W-1:0]   func;
    logic [ADDR_W-1:0]   inst_pc;
    logic [ADDR_W-1:0]   pc_plus4;

    // control flow
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                halt;
    logic                halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, inst, opcode, func, inst_pc, pc_plus4,
        input  inst_ready,
        input  redirect, redirect_pc, halt,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, inst, opcode, func, inst_pc, pc_plus4,
        output inst_ready,
        output redirect, redirect_pc, halt,
        input  halted
    );

endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, reads imem, hands one instruction at a time to decode.
// Latency: imem_ack edge -> inst_valid next cycle; peak one instruction every 2 cycles.
// Backpressure: holds inst/inst_pc/inst_valid stable and stops requesting until inst_ready.
//
// Ports: clk, rst_b (async active-low); bus (master) carries imem req/addr/ack/rdata,
//        decode inst_valid/inst_ready/inst/opcode/func/inst_pc/pc_plus4,
//        redirect/redirect_pc, halt/halted.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000,
    parameter logic [INST_W-1:0] NOP_WORD = instr_fetch_pkg::NOP_WORD
) (
    input  logic          clk,
    input  logic          rst_b,
    instr_fetch_if.master bus
);

    fetch_state_t      state,      state_nxt;
    logic [ADDR_W-1:0] pc,         pc_nxt;
    logic [ADDR_W-1:0] sq_addr,    sq_addr_nxt;   // address of the request being drained in SQUASH
    logic [INST_W-1:0] inst_q,     inst_nxt;
    logic [ADDR_W-1:0] inst_pc_q,  inst_pc_nxt;
    logic              valid_q,    valid_nxt;
    logic              halt_pend,  halt_pend_nxt;

    logic              halt_now;
    logic [ADDR_W-1:0] redir_pc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            sq_addr   <= '0;
            inst_q    <= NOP_WORD;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            sq_addr   <= sq_addr_nxt;
            inst_q    <= inst_nxt;
            inst_pc_q <= inst_pc_nxt;
            valid_q   <= valid_nxt;
            halt_pend <= halt_pend_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        sq_addr_nxt   = sq_addr;
        inst_nxt      = inst_q;
        inst_pc_nxt   = inst_pc_q;
        valid_nxt     = valid_q;
        // A halt seen this cycle counts immediately, so it beats a same-cycle redirect.
        halt_now      = halt_pend | bus.halt;
        halt_pend_nxt = halt_now;
        redir_pc      = bus.redirect_pc & ~ADDR_W'(3);

        unique case (state)
            FETCH: begin
                if (bus.imem_ack) begin
                    if (halt_now) begin
                        state_nxt = HALTED;
                    end else if (bus.redirect) begin
                        // Returning data belongs to the old path: drop it and refetch.
                        pc_nxt = redir_pc;
                    end else begin
                        inst_nxt    = bus.imem_rdata;
                        inst_pc_nxt = pc;
                        pc_nxt      = pc + ADDR_W'(PC_STEP);
                        valid_nxt   = 1'b1;
                        state_nxt   = HOLD;
                    end
                end else if (halt_now || bus.redirect) begin
                    // The request is already out; memory must still see it complete
                    // at the original address before we move on.
                    sq_addr_nxt = pc;
                    state_nxt   = SQUASH;
                    if (!halt_now) begin
                        pc_nxt = redir_pc;
                    end
                end
            end

            HOLD: begin
                if (bus.redirect || bus.inst_ready) begin
                    // Redirect outranks the handshake: the held word is dropped either way.
                    valid_nxt = 1'b0;
                    inst_nxt  = NOP_WORD;
                    if (halt_now) begin
                        state_nxt = HALTED;
                    end else begin
                        state_nxt = FETCH;
                        if (bus.redirect) begin
                            pc_nxt = redir_pc;
                        end
                    end
                end
            end

            SQUASH: begin
                if (!halt_now && bus.redirect) begin
                    pc_nxt = redir_pc;
                end
                if (bus.imem_ack) begin
                    state_nxt = halt_now ? HALTED : FETCH;
                end
            end

            HALTED: begin
                // Terminal until reset; redirects are ignored and pc stays frozen.
            end

            default: begin
                state_nxt = HALTED;
            end
        endcase
    end

    // Request is gated by rst_b so it stays low throughout reset and rises
    // in the first cycle after release.
    always_comb begin
        bus.imem_req  = rst_b && ((state == FETCH) || (state == SQUASH));
        bus.imem_addr = (state == SQUASH) ? sq_addr : pc;
    end

    assign bus.inst_valid = valid_q;
    assign bus.inst       = inst_q;
    assign bus.opcode     = get_opcode(inst_q);
    assign bus.func       = get_func(inst_q);
    assign bus.inst_pc    = inst_pc_q;
    assign bus.pc_plus4   = inst_pc_q + ADDR_W'(PC_STEP);
    assign bus.halted     = (state == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run with a scoreboard.
// Latency: n/a.
// Backpressure: randomized inst_ready and imem ack latency.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst_b;

    instr_fetch_if #(.ADDR_W(ADDR_W)) bus();

    instr_fetch #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RST_PC),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ack_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_deliv = 0;
    ack_t        exp_q[$];
    ack_t        last_ack;
    logic [31:0] model_pc = 32'h0;
    logic [31:0] want_data;
    bit          mem_en = 1'b0;
    bit          sb_en  = 1'b0;
    bit          found;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    // Memory responder: random 0..3 cycle latency; every ack pushed to the scoreboard.
    initial begin : mem_model
        bit          pend;
        int unsigned wait_cnt;
        logic [31:0] req_addr;
        pend     = 1'b0;
        wait_cnt = 0;
        req_addr = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!mem_en || !rst_b) begin
                pend = 1'b0;
            end else begin
                bus.imem_ack = 1'b0;
                if (pend) begin
                    chk("req_held", 32'(bus.imem_req), 32'd1);
                    chk("addr_stable", bus.imem_addr, req_addr);
                end else if (bus.imem_req) begin
                    pend     = 1'b1;
                    req_addr = bus.imem_addr;
                    wait_cnt = $urandom_range(0, 3);
                end
                if (pend) begin
                    if (wait_cnt == 0) begin
                        bus.imem_ack   = 1'b1;
                        bus.imem_rdata = mem_word(req_addr);
                        exp_q.push_back(ack_t'{addr: req_addr, data: bus.imem_rdata});
                        pend = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: every accepted instruction must be the next one on the program path
    // (last redirect target, otherwise previous + 4) and the latest memory response.
    always @(negedge clk) begin
        if (sb_en && rst_b && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
            n_deliv++;
            want_data = mem_word(model_pc);
            chk("sb_inst_pc",  bus.inst_pc, model_pc);
            chk("sb_inst",     bus.inst, want_data);
            chk("sb_opcode",   32'(bus.opcode), 32'(want_data[31:26]));
            chk("sb_func",     32'(bus.func), 32'(want_data[5:0]));
            chk("sb_pc_plus4", bus.pc_plus4, model_pc + 32'd4);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_queue: no memory response recorded, expected one for pc %h", model_pc);
            end else begin
                last_ack = exp_q[$];
                exp_q.delete();
                chk("sb_resp_addr", last_ack.addr, model_pc);
                chk("sb_resp_data", bus.inst, last_ack.data);
            end
            model_pc = model_pc + 32'd4;
        end
    end

    initial begin
        rst_b           = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;

        // ---- reset values ----
        repeat (3) tick();
        chk("rst_imem_req",   32'(bus.imem_req), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst",       bus.inst, 32'h0);
        chk("rst_inst_pc",    bus.inst_pc, 32'h0);
        chk("rst_halted",     32'(bus.halted), 32'd0);
        rst_b = 1'b1;
        #1;
        chk("first_req",  32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, RST_PC);

        // ---- first fetch, ack two cycles later ----
        tick();
        tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2008_0005;
        chk("wait_addr", bus.imem_addr, RST_PC);
        tick();
        bus.imem_ack = 1'b0;
        chk("cap_valid",    32'(bus.inst_valid), 32'd1);
        chk("cap_opcode",   32'(bus.opcode), 32'h08);
        chk("cap_func",     32'(bus.func), 32'h05);
        chk("cap_inst_pc",  bus.inst_pc, 32'h0040_0000);
        chk("cap_pc_plus4", bus.pc_plus4, 32'h0040_0004);

        // ---- decode stall ----
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_inst",  bus.inst, 32'h2008_0005);
            chk("stall_req",   32'(bus.imem_req), 32'd0);
            chk("stall_valid", 32'(bus.inst_valid), 32'd1);
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        chk("hs_req",   32'(bus.imem_req), 32'd1);
        chk("hs_addr",  bus.imem_addr, 32'h0040_0004);
        chk("hs_valid", 32'(bus.inst_valid), 32'd0);
        chk("hs_nop",   bus.inst, 32'h0);

        // ---- redirect in HOLD beats the handshake ----
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0109_4020;
        tick();
        bus.imem_ack = 1'b0;
        chk("hold2_pc", bus.inst_pc, 32'h0040_0004);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0040_0103;
        bus.inst_ready  = 1'b1;
        tick();
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b0;
        chk("rdh_valid", 32'(bus.inst_valid), 32'd0);
        chk("rdh_addr",  bus.imem_addr, 32'h0040_0100);

        // ---- redirect while a request is outstanding ----
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0040_0200;
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("sq_addr",  bus.imem_addr, 32'h0040_0100);
            chk("sq_req",   32'(bus.imem_req), 32'd1);
            chk("sq_valid", 32'(bus.inst_valid), 32'd0);
            tick();
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        chk("sq_ack_addr", bus.imem_addr, 32'h0040_0100);
        tick();
        bus.imem_ack = 1'b0;
        chk("sq_drop_valid", 32'(bus.inst_valid), 32'd0);
        chk("sq_new_addr",   bus.imem_addr, 32'h0040_0200);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h8C88_0004;
        tick();
        bus.imem_ack = 1'b0;
        chk("sq_cap_pc",     bus.inst_pc, 32'h0040_0200);
        chk("sq_cap_opcode", 32'(bus.opcode), 32'h23);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        chk("seq_addr", bus.imem_addr, 32'h0040_0204);

        // ---- redirect with same-cycle ack, then address wrap ----
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'h1111_1111;
        tick();
        bus.redirect = 1'b0;
        bus.imem_ack = 1'b0;
        chk("wrap_valid", 32'(bus.inst_valid), 32'd0);
        chk("wrap_addr",  bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0800_0010;
        tick();
        bus.imem_ack = 1'b0;
        chk("wrap_inst_pc",  bus.inst_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", bus.pc_plus4, 32'h0000_0000);
        chk("wrap_opcode",   32'(bus.opcode), 32'h02);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        chk("wrap_next_addr", bus.imem_addr, 32'h0000_0000);

        // ---- randomized run against the path model ----
        model_pc = 32'h0;
        exp_q.delete();
        n_deliv = 0;
        mem_en  = 1'b1;
        sb_en   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            bus.inst_ready = ($urandom_range(0, 2) != 0);
            if (i < 560 && $urandom_range(0, 7) == 0) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = 32'h0040_0000 + 32'($urandom_range(0, 4095));
                model_pc        = bus.redirect_pc & ~32'd3;
            end else begin
                bus.redirect = 1'b0;
            end
        end
        tick();
        bus.inst_ready = 1'b0;
        bus.redirect   = 1'b0;
        mem_en         = 1'b0;
        bus.imem_ack   = 1'b0;
        chk("deliveries", 32'(n_deliv >= 40), 32'd1);

        // Drain to a FETCH with the request on the bus.
        bus.inst_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus.imem_req && !bus.inst_valid) found = 1'b1;
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: no fetch request within 10 cycles, expected one");
        end
        sb_en          = 1'b0;
        bus.inst_ready = 1'b0;

        // ---- halt during an outstanding request ----
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        chk("halt_req_kept", 32'(bus.imem_req), 32'd1);
        chk("halt_addr",     bus.imem_addr, model_pc);
        chk("halt_not_yet",  32'(bus.halted), 32'd0);
        tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2008_0005;
        tick();
        bus.imem_ack = 1'b0;
        chk("halted",       32'(bus.halted), 32'd1);
        chk("halted_req",   32'(bus.imem_req), 32'd0);
        chk("halted_valid", 32'(bus.inst_valid), 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0040_0000;
        bus.inst_ready  = 1'b1;
        repeat (3) tick();
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b0;
        chk("halted_sticky", 32'(bus.halted), 32'd1);
        chk("halted_req2",   32'(bus.imem_req), 32'd0);
        chk("halted_valid2", 32'(bus.inst_valid), 32'd0);

        // ---- asynchronous reset mid-cycle ----
        @(posedge clk);
        #3;
        rst_b = 1'b0;
        #1;
        chk("arst_halted",   32'(bus.halted), 32'd0);
        chk("arst_req",      32'(bus.imem_req), 32'd0);
        chk("arst_valid",    32'(bus.inst_valid), 32'd0);
        chk("arst_inst",     bus.inst, 32'h0);
        chk("arst_inst_pc",  bus.inst_pc, 32'h0);
        chk("arst_pc_plus4", bus.pc_plus4, 32'h0000_0004);
        #2;
        rst_b = 1'b1;
        #1;
        chk("rel_req",  32'(bus.imem_req), 32'd1);
        chk("rel_addr", bus.imem_addr, RST_PC);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
